// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = $clog2(NREG);

   typedef logic [AW-1:0] reg_idx_t;

   typedef struct packed {
      reg_idx_t          rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

   typedef enum logic [0:0] {
      LSU_PRI   = 1'b0,
      ALU_FORCE = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
module rf_scoreboard
   import rf_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_valid,
   input  logic [AW-1:0] clr_rd,
   input  logic          set_valid,
   input  logic [AW-1:0] set_rd,
   input  logic          flush,
   input  logic [AW-1:0] chk_rs1,
   input  logic [AW-1:0] chk_rs2,
   output logic          hazard
);

   logic [NREG-1:0] pending_reg;
   logic [NREG-1:0] pending_next;

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_bit
         if (gi == 0) begin : g_zero
            assign pending_next[gi] = 1'b0;
         end else begin : g_live
            logic set_hit;
            logic clr_hit;
            assign set_hit = set_valid && (set_rd == reg_idx_t'(gi));
            assign clr_hit = clr_valid && (clr_rd == reg_idx_t'(gi));
            // Flush first, then the writeback clear; a same-cycle issue always re-marks the bit.
            assign pending_next[gi] = set_hit || (!flush && pending_reg[gi] && !clr_hit);
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   assign hazard = ((chk_rs1 != '0) && pending_reg[chk_rs1]) ||
                   ((chk_rs2 != '0) && pending_reg[chk_rs2]);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between ALU and LSU writeback,
// with an anti-starvation override for the ALU and a pending-write scoreboard.
module regfile_wb_arbiter
   import rf_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_valid,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            lsu_valid,
   input  logic [AW-1:0]   lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            lsu_ready,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic            flush,
   input  logic [AW-1:0]   chk_rs1,
   input  logic [AW-1:0]   chk_rs2,
   output logic            hazard,
   output logic            rf_we,
   output logic [AW-1:0]   rf_waddr,
   output logic [XLEN-1:0] rf_wdata
);

   localparam int            CW      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

   arb_state_t      state_reg;
   logic [CW-1:0]   starve_cnt_reg;
   logic [CW-1:0]   starve_cnt_next;
   logic            rf_we_reg;
   logic [AW-1:0]   rf_waddr_reg;
   logic [XLEN-1:0] rf_wdata_reg;

   wb_req_t alu_req;
   wb_req_t lsu_req;
   wb_req_t win_req;
   logic    xfer;
   logic    wr_en;

   assign alu_req = '{rd: alu_rd, data: alu_data};
   assign lsu_req = '{rd: lsu_rd, data: lsu_data};

   // Grants are gated by rst_n so nothing is accepted while the write stage is held in reset.
   always_comb begin
      alu_ready = rst_n && alu_valid && ((state_reg == ALU_FORCE) || !lsu_valid);
      lsu_ready = rst_n && lsu_valid && !alu_ready;
   end

   assign xfer    = alu_ready || lsu_ready;
   assign win_req = alu_ready ? alu_req : lsu_req;
   assign wr_en   = xfer && (win_req.rd != '0);

   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (!alu_valid || alu_ready) begin
         starve_cnt_next = '0;
      end else if (starve_cnt_reg != CNT_MAX) begin
         starve_cnt_next = starve_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= LSU_PRI;
         starve_cnt_reg <= '0;
         rf_we_reg      <= 1'b0;
         rf_waddr_reg   <= '0;
         rf_wdata_reg   <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
         case (state_reg)
            // Switch as the count reaches the limit so the ALU wins on that very next cycle.
            LSU_PRI:   if (starve_cnt_next == CNT_MAX) state_reg <= ALU_FORCE;
            ALU_FORCE: if (alu_ready || !alu_valid)    state_reg <= LSU_PRI;
            default:   state_reg <= LSU_PRI;
         endcase
         rf_we_reg <= wr_en;
         if (wr_en) begin
            rf_waddr_reg <= win_req.rd;
            rf_wdata_reg <= win_req.data;
         end
      end
   end

   assign rf_we    = rf_we_reg;
   assign rf_waddr = rf_waddr_reg;
   assign rf_wdata = rf_wdata_reg;

   rf_scoreboard u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_valid (xfer),
      .clr_rd    (win_req.rd),
      .set_valid (issue_valid),
      .set_rd    (issue_rd),
      .flush     (flush),
      .chk_rs1   (chk_rs1),
      .chk_rs2   (chk_rs2),
      .hazard    (hazard)
   );

endmodule
